// File: rtl/mod_counter_param.sv
// mod_counter_param: modulo counter with a runtime-programmable terminal value.
// Supports up/down counting, count enable, synchronous load with clamping,
// a registered match flag, a one-cycle wrap pulse and a saturating pass counter.
module mod_counter_param #(
  parameter int WIDTH      = 4,
  parameter int WRAP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [WIDTH-1:0]      match_val,
  input  logic                  clr_wraps,
  output logic [WIDTH-1:0]      count,
  output logic                  match,
  output logic                  wrap,
  output logic [WRAP_WIDTH-1:0] wrap_cnt,
  output logic                  wrap_sat
);

  logic [WIDTH-1:0]      count_nxt;
  logic                  wrap_evt;
  logic [WRAP_WIDTH-1:0] wrap_cnt_nxt;

  // Next count and wrap event: load beats enable; comparisons against limit
  // keep the count inside 0..limit even when limit moves under it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    count_nxt = count;
    wrap_evt  = 1'b0;
    if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (dir) begin
        if (count >= limit) begin
          count_nxt = '0;
          wrap_evt  = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          count_nxt = limit;
          wrap_evt  = 1'b1;
        end else if (count > limit) begin
          count_nxt = limit;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
    end
  end

  // Next pass count: clear wins over a simultaneous wrap, increments stick at all-ones.
  always_comb begin
    wrap_cnt_nxt = wrap_cnt;
    if (clr_wraps) begin
      wrap_cnt_nxt = '0;
    end else if (wrap_evt && (wrap_cnt != '1)) begin
      wrap_cnt_nxt = wrap_cnt + 1'b1;
    end
  end

  // State register: synchronous reset, flags computed from the next values so
  // they line up with the count they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      count    <= '0;
      match    <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      wrap_sat <= 1'b0;
    end else begin
      count    <= count_nxt;
      match    <= (count_nxt == match_val);
      wrap     <= wrap_evt;
      wrap_cnt <= wrap_cnt_nxt;
      wrap_sat <= (wrap_cnt_nxt == '1);
    end
  end

endmodule

// File: tb/tb_mod_counter_param.sv
// tb_mod_counter_param: vector table, hand-written corner sequences and
// randomized stimulus against a behavioural model of mod_counter_param.
module tb_mod_counter_param;

  localparam int WIDTH      = 4;
  localparam int WRAP_WIDTH = 2;
  localparam int WCMAX      = (1 << WRAP_WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  en = 1'b0;
  logic                  dir = 1'b1;
  logic                  load = 1'b0;
  logic [WIDTH-1:0]      load_val = '0;
  logic [WIDTH-1:0]      limit = '0;
  logic [WIDTH-1:0]      match_val = '0;
  logic                  clr_wraps = 1'b0;
  logic [WIDTH-1:0]      count;
  logic                  match;
  logic                  wrap;
  logic [WRAP_WIDTH-1:0] wrap_cnt;
  logic                  wrap_sat;

  mod_counter_param #(.WIDTH(WIDTH), .WRAP_WIDTH(WRAP_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .limit(limit), .match_val(match_val),
    .clr_wraps(clr_wraps), .count(count), .match(match), .wrap(wrap),
    .wrap_cnt(wrap_cnt), .wrap_sat(wrap_sat)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Behavioural model state, plain integers.
  int m_count, m_match, m_wrap, m_wcnt, m_sat;

  typedef struct {
    logic rn, en, dir, ld, clr;
    int   lv, lim, mv;
    int   c, m, w, wc, s;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic e, input logic d,
                            input logic ld, input int lv, input int lim,
                            input int mv, input logic clr);
    int nc;
    int w;
    if (!rn) begin
      m_count = 0; m_match = 0; m_wrap = 0; m_wcnt = 0; m_sat = 0;
      return;
    end
    nc = m_count;
    w  = 0;
    if (ld) begin
      nc = (lv < lim) ? lv : lim;
    end else if (e && d) begin
      if (m_count >= lim) begin nc = 0; w = 1; end
      else nc = m_count + 1;
    end else if (e) begin
      if (m_count == 0) begin nc = lim; w = 1; end
      else if (m_count > lim) nc = lim;
      else nc = m_count - 1;
    end
    m_count = nc;
    m_match = (nc == mv) ? 1 : 0;
    m_wrap  = w;
    if (clr) m_wcnt = 0;
    else if (w == 1) m_wcnt = (m_wcnt + 1 > WCMAX) ? WCMAX : m_wcnt + 1;
    m_sat = (m_wcnt == WCMAX) ? 1 : 0;
  endtask

  // Apply one set of inputs across one rising edge; outputs are valid on return.
  task automatic cyc(input logic rn, input logic e, input logic d, input logic ld,
                     input int lv, input int lim, input int mv, input logic clr);
    reset_n   = rn;
    en        = e;
    dir       = d;
    load      = ld;
    load_val  = lv[WIDTH-1:0];
    limit     = lim[WIDTH-1:0];
    match_val = mv[WIDTH-1:0];
    clr_wraps = clr;
    model_step(rn, e, d, ld, lv, lim, mv, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},    int'(count),    m_count);
    check({tag, ".match"},    int'(match),    m_match);
    check({tag, ".wrap"},     int'(wrap),     m_wrap);
    check({tag, ".wrap_cnt"}, int'(wrap_cnt), m_wcnt);
    check({tag, ".wrap_sat"}, int'(wrap_sat), m_sat);
  endtask

  initial begin
    // rn en dir ld clr  lv lim mv   count match wrap wcnt sat
    // Base sequence: limit=2, match_val=2, counting up.
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 0,2,2, 0,0,0,0,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 1,0,0,0,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 2,1,0,0,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 0,0,1,1,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 1,0,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 2,1,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 0,0,1,2,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 1,0,0,2,0});
    vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0, 0,2,2, 2,1,0,2,0});
    // Down count: limit=5, match_val=3, from count=0.
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 0,5,3, 0,0,0,0,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 5,0,1,1,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 4,0,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 3,1,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 2,0,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 1,0,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 0,0,0,1,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0, 0,5,3, 5,0,1,2,0});
    // Load clamps to limit and takes priority over enable; wrap_cnt untouched.
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,1'b0, 9,6,3, 6,0,0,2,0});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,1'b0, 4,6,4, 4,1,0,2,0});

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cyc(vecs[i].rn, vecs[i].en, vecs[i].dir, vecs[i].ld,
          vecs[i].lv, vecs[i].lim, vecs[i].mv, vecs[i].clr);
      check({tag, ".count"},    int'(count),    vecs[i].c);
      check({tag, ".match"},    int'(match),    vecs[i].m);
      check({tag, ".wrap"},     int'(wrap),     vecs[i].w);
      check({tag, ".wrap_cnt"}, int'(wrap_cnt), vecs[i].wc);
      check({tag, ".wrap_sat"}, int'(wrap_sat), vecs[i].s);
    end

    // Limit lowered below count while counting up: wrap to 0.
    cyc(1, 0, 1, 1, 7, 10, 15, 0);
    check("lim_up.preload", int'(count), 7);
    cyc(1, 1, 1, 0, 0, 3, 15, 0);
    check("lim_up.count", int'(count), 0);
    check("lim_up.wrap",  int'(wrap),  1);
    // Limit lowered below count while counting down: clamp, no wrap.
    cyc(1, 0, 0, 1, 7, 10, 15, 0);
    check("lim_dn.preload", int'(count), 7);
    cyc(1, 1, 0, 0, 0, 3, 15, 0);
    check("lim_dn.count", int'(count), 3);
    check("lim_dn.wrap",  int'(wrap),  0);

    // Saturation with limit=0: wrap every edge, wrap_cnt sticks at 3.
    cyc(0, 0, 1, 0, 0, 0, 15, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 0, 0, 0, 15, 0);
      check($sformatf("sat%0d.count", i),    int'(count),    0);
      check($sformatf("sat%0d.wrap", i),     int'(wrap),     1);
      check($sformatf("sat%0d.wrap_cnt", i), int'(wrap_cnt), (i < 3) ? i + 1 : 3);
      check($sformatf("sat%0d.wrap_sat", i), int'(wrap_sat), (i >= 2) ? 1 : 0);
    end
    cyc(1, 1, 0, 0, 0, 0, 15, 1);
    check("clr.wrap",     int'(wrap),     1);
    check("clr.wrap_cnt", int'(wrap_cnt), 0);
    check("clr.wrap_sat", int'(wrap_sat), 0);

    // Reset mid-operation overrides load and enable.
    cyc(1, 1, 1, 0, 0, 0, 15, 0);
    cyc(1, 0, 1, 1, 5, 10, 5, 0);
    check("mid.preload", int'(count), 5);
    check("mid.prematch", int'(match), 1);
    cyc(0, 1, 1, 1, 9, 10, 0, 0);
    check("rst.count",    int'(count),    0);
    check("rst.match",    int'(match),    0);
    check("rst.wrap",     int'(wrap),     0);
    check("rst.wrap_cnt", int'(wrap_cnt), 0);
    check("rst.wrap_sat", int'(wrap_sat), 0);
    cyc(1, 0, 1, 0, 0, 10, 0, 0);
    check("post_rst.match", int'(match), 1);
    check("post_rst.count", int'(count), 0);

    // Randomized stimulus against the model.
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic rn, e, d, ld, clr;
      int lim;
      rn  = ($urandom_range(0, 39) != 0);
      e   = ($urandom_range(0, 3) != 0);
      d   = $urandom_range(0, 1);
      ld  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 15) == 0);
      lim = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
      cyc(rn, e, d, ld, $urandom_range(0, 15), lim, $urandom_range(0, 15), clr);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mod_counter_param.md
Name: mod_counter_param

Overview:
Parametrised modulo counter with runtime-programmable terminal value, up/down direction, count enable, synchronous load, registered match flag and wrap pulse. A saturating wrap counter tracks completed passes. The block is the general sequencing counter for the clustering datapath: cluster/feature index stepping, phase sequencing and pass counting. Configured with limit=2, match_val=2, direction up and enable high, it counts 0,1,2,0,… with a flag while count=2.

Parameters:
WIDTH, 4, bit width of count, limit, load_val and match_val (WIDTH >= 1)
WRAP_WIDTH, 8, bit width of the saturating wrap counter (WRAP_WIDTH >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled at rising edge of clk
en  input  1  count enable
dir  input  1  1 = count up, 0 = count down
load  input  1  synchronous load request
load_val  input  WIDTH  value for load
limit  input  WIDTH  terminal value; count range is 0..limit inclusive
match_val  input  WIDTH  compare value for match
clr_wraps  input  1  clears wrap_cnt
count  output  WIDTH  current count (registered)
match  output  1  registered; high iff count == match_val (match_val as sampled at the same edge)
wrap  output  1  one-cycle pulse, high in the cycle following a wrap edge
wrap_cnt  output  WRAP_WIDTH  number of wraps since reset/clear, saturating
wrap_sat  output  1  high while wrap_cnt == all-ones

Behaviour:
- Reset (reset_n=0 at edge): count=0, match=0, wrap=0, wrap_cnt=0, wrap_sat=0. match stays 0 even if match_val=0; it re-evaluates at the first non-reset edge. Reset overrides all inputs, mid-operation included.
- Priority per edge for count: reset > load > en. With en=0 and load=0, count holds and wrap=0.
- Load: count <= min(load_val, limit) (clamp). wrap=0. wrap_cnt is unchanged. en and dir are ignored that cycle.
- Up (en=1, dir=1):
  - if count >= limit: count <= 0, wrap pulse.
  - else count <= count+1.
  - If limit is lowered below the current count, the next enabled edge wraps to 0.
- Down (en=1, dir=0):
  - if count == 0: count <= limit, wrap pulse.
  - else if count > limit: count <= limit, no wrap.
  - else count <= count-1.
- limit == 0: count stays 0; every enabled edge produces a wrap pulse in either direction.
- All arithmetic is unsigned WIDTH-bit; no overflow is possible because of the >= limit compare.
- match: registered every edge as (next count == match_val). It is therefore aligned with count, with zero added latency relative to count. It also updates while the counter holds, if match_val changes.
- wrap: registered, aligned with the count value after the wrap, high for exactly one cycle per wrap event. Consecutive wraps (limit=0) keep it high continuously.
- wrap_cnt:
  - increments on each wrap event and saturates at 2^WRAP_WIDTH-1.
  - clr_wraps sets it to 0; clr_wraps beats a simultaneous wrap (result 0).
  - Not affected by load.
- wrap_sat: registered, equal to (next wrap_cnt == all-ones).
- There is no internal state beyond count, match, wrap, wrap_cnt and wrap_sat.

Test Plan:
- Base sequence: WIDTH=4; reset, then limit=2, match_val=2, dir=1, en=1 for 9 cycles.
  - count=0,1,2,0,1,2,0,1,2.
  - match=1 exactly when count=2.
  - wrap=1 on each count=0 following 2.
  - wrap_cnt ends at 2.
- Down count: limit=5, dir=0, en=1 from count=0.
  - count=5,4,3,2,1,0,5.
  - wrap high with the first 5 and again with the second 5.
  - match_val=3 gives match only at count=3.
- Load clamp and priority: limit=6, load=1, load_val=9, en=1 → count=6, wrap=0. Then load_val=4 with load=1 → count=4.
- Limit change mid-count: count=7 with limit=10, up. Set limit=3 → next edge count=0 with wrap=1. In down mode with count=7 and limit=3 → count=3, wrap=0.
- Saturation and clear: WRAP_WIDTH=2, limit=0, en=1 for 5 edges.
  - wrap stays high continuously.
  - wrap_cnt=1,2,3,3,3; wrap_sat=1 from the third edge.
  - clr_wraps=1 together with a wrap → wrap_cnt=0, wrap_sat=0.
- Reset mid-operation: count=5, en=1, load=1, reset_n=0 at an edge → count=0, match=0, wrap=0, wrap_cnt=0. With reset_n=1, match_val=0, en=0 at the next edge → match=1.
